// File: rtl/io_sequence_checker.sv
// On-chip sequence checker: confirms that a programmed list of masked/tagged
// values shows up in order on an observation bus, with per-step hold and timeout.
module io_sequence_checker #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 2,
  parameter int TIMEOUT_W = 20,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [WIDTH-1:0]     obs_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic                 prog_we_i,
  input  logic [AW-1:0]        prog_addr_i,
  input  logic [WIDTH-1:0]     prog_data_i,
  input  logic [WIDTH-1:0]     prog_mask_i,
  input  logic [TAG_W-1:0]     prog_tag_i,
  input  logic [AW:0]          seq_len_i,
  input  logic [7:0]           hold_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic [AW-1:0]        step_o,
  output logic [AW-1:0]        fail_step_o
);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     data_mem [DEPTH];
  logic [WIDTH-1:0]     mask_mem [DEPTH];
  logic [TAG_W-1:0]     tag_mem  [DEPTH];

  logic [WIDTH-1:0]     obs_reg;
  logic [TAG_W-1:0]     tag_reg;
  logic [AW-1:0]        step_reg, step_next;
  logic [AW-1:0]        fail_step_reg, fail_step_next;
  logic [7:0]           hcnt_reg, hcnt_next;
  logic [TIMEOUT_W-1:0] tcnt_reg, tcnt_next;
  logic [AW:0]          len_reg, len_next;
  logic [7:0]           hold_reg, hold_next;
  logic [TIMEOUT_W-1:0] timeout_reg, timeout_next;

  logic match, step_done, timed_out, last_step;

  // The table must clear on reset, so it lives in flops rather than block RAM.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        mask_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
    end else if (prog_we_i && state_reg != RUN) begin
      data_mem[prog_addr_i] <= prog_data_i;
      mask_mem[prog_addr_i] <= prog_mask_i;
      tag_mem[prog_addr_i]  <= prog_tag_i;
    end
  end

  assign match     = (((obs_reg ^ data_mem[step_reg]) & mask_mem[step_reg]) == '0) &&
                     (tag_reg == tag_mem[step_reg]);
  assign step_done = match && (({1'b0, hcnt_reg} + 9'd1) == {1'b0, hold_reg});
  assign timed_out = (timeout_reg != '0) && (tcnt_reg == timeout_reg - TIMEOUT_W'(1));
  assign last_step = ({1'b0, step_reg} == len_reg - (AW+1)'(1));

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    fail_step_next = fail_step_reg;
    hcnt_next      = hcnt_reg;
    tcnt_next      = tcnt_reg;
    len_next       = len_reg;
    hold_next      = hold_reg;
    timeout_next   = timeout_reg;
    if (abort_i) begin
      state_next = IDLE;
      hcnt_next  = '0;
      tcnt_next  = '0;
    end else begin
      case (state_reg)
        IDLE, PASS, FAIL: begin
          if (start_i) begin
            step_next      = '0;
            fail_step_next = '0;
            hcnt_next      = '0;
            tcnt_next      = '0;
            hold_next      = (hold_i == 8'd0) ? 8'd1 : hold_i;
            timeout_next   = timeout_i;
            if (seq_len_i == '0) begin
              len_next   = '0;
              state_next = PASS;
            end else begin
              len_next   = (seq_len_i > LEN_MAX) ? LEN_MAX : seq_len_i;
              state_next = RUN;
            end
          end
        end
        RUN: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (step_done) begin
            hcnt_next = '0;
            tcnt_next = '0;
            if (last_step) state_next = PASS;
            else           step_next  = step_reg + AW'(1);
          end else if (timed_out) begin
            state_next     = FAIL;
            fail_step_next = step_reg;
          end else begin
            hcnt_next = match ? hcnt_reg + 8'd1 : 8'd0;
            tcnt_next = tcnt_reg + TIMEOUT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      obs_reg       <= '0;
      tag_reg       <= '0;
      step_reg      <= '0;
      fail_step_reg <= '0;
      hcnt_reg      <= '0;
      tcnt_reg      <= '0;
      len_reg       <= '0;
      hold_reg      <= 8'd1;
      timeout_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      obs_reg       <= obs_i;
      tag_reg       <= tag_i;
      step_reg      <= step_next;
      fail_step_reg <= fail_step_next;
      hcnt_reg      <= hcnt_next;
      tcnt_reg      <= tcnt_next;
      len_reg       <= len_next;
      hold_reg      <= hold_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign busy_o      = (state_reg == RUN);
  assign pass_o      = (state_reg == PASS);
  assign fail_o      = (state_reg == FAIL);
  assign step_o      = step_reg;
  assign fail_step_o = fail_step_reg;

endmodule

// File: tb/tb_io_sequence_checker.sv
// Directed bench for io_sequence_checker: nominal, hold, timeout, mask/tag,
// control edges and mid-run reset, with hand-computed expectations.
module tb_io_sequence_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] obs;
  logic [1:0]  tag;
  logic        prog_we;
  logic [2:0]  prog_addr;
  logic [15:0] prog_data;
  logic [15:0] prog_mask;
  logic [1:0]  prog_tag;
  logic [3:0]  seq_len;
  logic [7:0]  hold;
  logic [19:0] timeout;
  logic        start;
  logic        abort;
  logic        busy, pass, fail;
  logic [2:0]  step, fail_step;

  int passed = 0;
  int total  = 0;

  io_sequence_checker dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .obs_i       (obs),
    .tag_i       (tag),
    .prog_we_i   (prog_we),
    .prog_addr_i (prog_addr),
    .prog_data_i (prog_data),
    .prog_mask_i (prog_mask),
    .prog_tag_i  (prog_tag),
    .seq_len_i   (seq_len),
    .hold_i      (hold),
    .timeout_i   (timeout),
    .start_i     (start),
    .abort_i     (abort),
    .busy_o      (busy),
    .pass_o      (pass),
    .fail_o      (fail),
    .step_o      (step),
    .fail_step_o (fail_step)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
      $display("check %s got=%0h exp=%0h ok", name, got, exp);
    end else begin
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic b, input logic p, input logic f);
    chk({name, "_busy"}, {31'd0, busy}, {31'd0, b});
    chk({name, "_pass"}, {31'd0, pass}, {31'd0, p});
    chk({name, "_fail"}, {31'd0, fail}, {31'd0, f});
  endtask

  task automatic prog(input logic [2:0] a, input logic [15:0] d, input logic [15:0] m,
                      input logic [1:0] t);
    prog_addr = a; prog_data = d; prog_mask = m; prog_tag = t;
    prog_we = 1'b1;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic go(input logic [3:0] l, input logic [7:0] h, input logic [19:0] t);
    seq_len = l; hold = h; timeout = t;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; obs = '0; tag = '0; prog_we = 1'b0; prog_addr = '0;
    prog_data = '0; prog_mask = '0; prog_tag = '0; seq_len = '0;
    hold = '0; timeout = '0; start = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_step", {29'd0, step}, 32'd0);
    chk("reset_fail_step", {29'd0, fail_step}, 32'd0);

    // Nominal 255 then 1
    prog(3'd0, 16'h00FF, 16'hFFFF, 2'b00);
    prog(3'd1, 16'h0001, 16'hFFFF, 2'b00);
    go(4'd2, 8'd1, 20'd0);
    chk_flags("nom_start", 1'b1, 1'b0, 1'b0);
    obs = 16'h00FF;
    tick();
    chk("nom_step_a", {29'd0, step}, 32'd0);
    tick();
    chk("nom_step_b", {29'd0, step}, 32'd1);
    tick();
    obs = 16'h0001;
    tick();
    chk("nom_pass_early", {31'd0, pass}, 32'd0);
    tick();
    chk_flags("nom_done", 1'b0, 1'b1, 1'b0);
    chk("nom_step_end", {29'd0, step}, 32'd1);

    // Hold filter with a one-cycle glitch
    obs = 16'h0000;
    go(4'd2, 8'd4, 20'd0);
    obs = 16'h00FF;
    repeat (3) tick();
    obs = 16'h0000;
    tick();
    obs = 16'h00FF;
    repeat (4) tick();
    chk("hold_step_pre", {29'd0, step}, 32'd0);
    tick();
    chk("hold_step_adv", {29'd0, step}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_flags("hold_abort", 1'b0, 1'b0, 1'b0);

    // Timeout on step 1
    obs = 16'h00FF;
    go(4'd2, 8'd1, 20'd100);
    tick();
    chk("to_step1", {29'd0, step}, 32'd1);
    obs = 16'h0000;
    repeat (99) tick();
    chk_flags("to_before", 1'b1, 1'b0, 1'b0);
    tick();
    chk_flags("to_hit", 1'b0, 1'b0, 1'b1);
    chk("to_fail_step", {29'd0, fail_step}, 32'd1);

    // Mask and tag
    prog(3'd0, 16'h00F0, 16'h00F0, 2'b01);
    obs = 16'h12F7; tag = 2'b00;
    go(4'd1, 8'd1, 20'd0);
    repeat (3) tick();
    chk_flags("mt_wrongtag", 1'b1, 1'b0, 1'b0);
    chk("mt_fail_step_clr", {29'd0, fail_step}, 32'd0);
    tag = 2'b01;
    tick();
    chk("mt_pass_early", {31'd0, pass}, 32'd0);
    tick();
    chk_flags("mt_done", 1'b0, 1'b1, 1'b0);

    // Writes and start while busy are ignored
    obs = 16'h0000; tag = 2'b00;
    go(4'd1, 8'd1, 20'd0);
    prog(3'd0, 16'h0000, 16'h0000, 2'b00);
    go(4'd0, 8'd1, 20'd0);
    chk_flags("busy_start", 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk_flags("busy_prog", 1'b1, 1'b0, 1'b0);
    obs = 16'h00F0; tag = 2'b01;
    tick(); tick();
    chk_flags("busy_orig_entry", 1'b0, 1'b1, 1'b0);

    // start and abort together
    seq_len = 4'd2; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_flags("start_abort", 1'b0, 1'b0, 1'b0);
    tick();
    chk("start_abort_idle", {31'd0, busy}, 32'd0);

    // Zero-length sequence
    go(4'd0, 8'd1, 20'd0);
    chk_flags("len0", 1'b0, 1'b1, 1'b0);

    // Mid-run reset, then rerun on the cleared table (length clamps to 8)
    prog(3'd0, 16'h00FF, 16'hFFFF, 2'b00);
    prog(3'd1, 16'h0001, 16'hFFFF, 2'b00);
    tag = 2'b00; obs = 16'h00FF;
    go(4'd2, 8'd1, 20'd0);
    tick();
    chk("rst_step1", {29'd0, step}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_flags("rst_mid", 1'b0, 1'b0, 1'b0);
    chk("rst_mid_step", {29'd0, step}, 32'd0);
    obs = 16'h1234;
    go(4'd12, 8'd1, 20'd0);
    chk_flags("rerun_start", 1'b1, 1'b0, 1'b0);
    repeat (7) tick();
    chk("rerun_step7", {29'd0, step}, 32'd7);
    chk("rerun_pass_early", {31'd0, pass}, 32'd0);
    tick();
    chk_flags("rerun_done", 1'b0, 1'b1, 1'b0);
    chk("rerun_step_end", {29'd0, step}, 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
